// File: rtl/sync_fifo_param.sv
// sync_fifo_param: single-clock FIFO with exact count, almost flags, error pulses.
// Define FIFO_FWFT_EN for first-word fall-through reads; default is registered read.
module sync_fifo_param #(
  parameter int WIDTH    = 32,
  parameter int DEPTH    = 8,
  parameter int AF_LEVEL = DEPTH-2,
  parameter int AE_LEVEL = 2
) (
  input  logic                       Clk,
  input  logic                       Rst,
  input  logic                       EN,
  input  logic                       WR,
  input  logic                       RD,
  input  logic [WIDTH-1:0]           dataIn,
  output logic [WIDTH-1:0]           dataOut,
  output logic                       EMPTY,
  output logic                       FULL,
  output logic                       ALMOST_EMPTY,
  output logic                       ALMOST_FULL,
  output logic [$clog2(DEPTH+1)-1:0] Count,
  output logic                       OVERFLOW,
  output logic                       UNDERFLOW
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH+1);
  localparam logic [CW-1:0] FULL_C = CW'(DEPTH);
  localparam logic [CW-1:0] AF_C   = CW'(AF_LEVEL);
  localparam logic [CW-1:0] AE_C   = CW'(AE_LEVEL);

  logic [WIDTH-1:0] mem_q [DEPTH];

  logic [AW-1:0] rptr_q, rptr_d;
  logic [AW-1:0] wptr_q, wptr_d;
  logic [CW-1:0] count_q, count_d;
  logic          ovf_q, ovf_d;
  logic          udf_q, udf_d;
  logic          rd_ok, wr_ok, mem_we;

  // Flags decode the registered count only
  always_comb begin
    EMPTY        = (count_q == '0);
    FULL         = (count_q == FULL_C);
    ALMOST_EMPTY = (count_q <= AE_C);
    ALMOST_FULL  = (count_q >= AF_C);
    Count        = count_q;
    OVERFLOW     = ovf_q;
    UNDERFLOW    = udf_q;
  end

  // Accept decisions, pointer/count next state and error pulses
  always_comb begin
    rd_ok   = EN & RD & ~EMPTY;
    wr_ok   = EN & WR & (~FULL | rd_ok);
    mem_we  = wr_ok & ~Rst;
    rptr_d  = rptr_q;
    wptr_d  = wptr_q;
    count_d = count_q;
    ovf_d   = EN & WR & ~wr_ok;
    udf_d   = EN & RD & ~rd_ok;
    if (rd_ok) rptr_d = rptr_q + 1'b1;
    if (wr_ok) wptr_d = wptr_q + 1'b1;
    unique case ({wr_ok, rd_ok})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
  end

  // Storage array, never cleared by reset
  always_ff @(posedge Clk) begin
    if (mem_we) mem_q[wptr_q] <= dataIn;
  end

  // Control state register, reset wins over enable
  always_ff @(posedge Clk) begin
    if (Rst) begin
      rptr_q  <= '0;
      wptr_q  <= '0;
      count_q <= '0;
      ovf_q   <= 1'b0;
      udf_q   <= 1'b0;
    end else begin
      rptr_q  <= rptr_d;
      wptr_q  <= wptr_d;
      count_q <= count_d;
      ovf_q   <= ovf_d;
      udf_q   <= udf_d;
    end
  end

`ifdef FIFO_FWFT_EN
  // Head word shown directly; RD only pops
  always_comb begin
    dataOut = mem_q[rptr_q];
  end
`else
  logic [WIDTH-1:0] dout_q, dout_d;

  // Registered read: load head on accepted read, else hold
  always_comb begin
    dout_d = dout_q;
    if (rd_ok) dout_d = mem_q[rptr_q];
  end

  // Output data register
  always_ff @(posedge Clk) begin
    if (Rst) dout_q <= '0;
    else     dout_q <= dout_d;
  end

  // Drive port from the output register
  always_comb begin
    dataOut = dout_q;
  end
`endif

endmodule

// File: tb/tb_sync_fifo_param.sv
// tb_sync_fifo_param: scoreboard bench for sync_fifo_param (8x32, AF=6, AE=2).
// Stimulus pushes expected post-edge snapshots; a monitor pops and compares.
module tb_sync_fifo_param;

  logic        Clk = 1'b0;
  logic        Rst = 1'b0;
  logic        EN = 1'b0;
  logic        WR = 1'b0;
  logic        RD = 1'b0;
  logic [31:0] dataIn = '0;
  logic [31:0] dataOut;
  logic        EMPTY, FULL, ALMOST_EMPTY, ALMOST_FULL;
  logic [3:0]  Count;
  logic        OVERFLOW, UNDERFLOW;

  sync_fifo_param #(
    .WIDTH(32), .DEPTH(8), .AF_LEVEL(6), .AE_LEVEL(2)
  ) dut (
    .Clk(Clk), .Rst(Rst), .EN(EN), .WR(WR), .RD(RD),
    .dataIn(dataIn), .dataOut(dataOut),
    .EMPTY(EMPTY), .FULL(FULL),
    .ALMOST_EMPTY(ALMOST_EMPTY), .ALMOST_FULL(ALMOST_FULL),
    .Count(Count), .OVERFLOW(OVERFLOW), .UNDERFLOW(UNDERFLOW)
  );

  always #5 Clk = ~Clk;

  typedef struct {
    logic [31:0] dout;
    logic        chkd;
    logic [3:0]  cnt;
    logic        e, f, ae, af, ov, un;
  } snap_t;

  snap_t       sq[$];
  logic [31:0] mq[$];
  logic [31:0] dout_m = '0;
  int          total = 0;
  int          bad = 0;

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s t=%0t act=%h exp=%h", nm, $time, act, exp);
    end
  endtask

  task automatic step(input bit rst, input bit en, input bit wr,
                      input bit rd, input logic [31:0] din);
    snap_t s;
    bit    rok, wok, ov, un;
    @(negedge Clk);
    Rst = rst; EN = en; WR = wr; RD = rd; dataIn = din;
    ov = 1'b0; un = 1'b0;
    if (rst) begin
      mq.delete();
      dout_m = '0;
    end else if (en) begin
      rok = rd && (mq.size() > 0);
      wok = wr && ((mq.size() < 8) || rok);
      ov  = wr && !wok;
      un  = rd && !rok;
      if (rok) dout_m = mq.pop_front();
      if (wok) mq.push_back(din);
    end
    s.cnt = 4'(mq.size());
    s.e   = (mq.size() == 0);
    s.f   = (mq.size() == 8);
    s.ae  = (mq.size() <= 2);
    s.af  = (mq.size() >= 6);
    s.ov  = ov;
    s.un  = un;
`ifdef FIFO_FWFT_EN
    s.chkd = (mq.size() > 0);
    s.dout = (mq.size() > 0) ? mq[0] : '0;
`else
    s.chkd = 1'b1;
    s.dout = dout_m;
`endif
    sq.push_back(s);
  endtask

  initial begin : monitor
    snap_t s;
    forever begin
      @(posedge Clk);
      #1;
      if (sq.size() > 0) begin
        s = sq.pop_front();
        chk("count", 32'(Count), 32'(s.cnt));
        chk("empty", 32'(EMPTY), 32'(s.e));
        chk("full", 32'(FULL), 32'(s.f));
        chk("aempty", 32'(ALMOST_EMPTY), 32'(s.ae));
        chk("afull", 32'(ALMOST_FULL), 32'(s.af));
        chk("ovf", 32'(OVERFLOW), 32'(s.ov));
        chk("udf", 32'(UNDERFLOW), 32'(s.un));
        if (s.chkd) chk("dout", dataOut, s.dout);
      end
    end
  end

  initial begin : stim
    int n;
    step(1, 0, 0, 0, 0);
    step(1, 1, 0, 0, 0);
    for (int i = 0; i < 8; i++) step(0, 1, 1, 0, 32'h11 * (i + 1));
    step(0, 1, 1, 0, 32'h99);
    for (int i = 0; i < 8; i++) step(0, 1, 0, 1, 0);
    step(0, 1, 0, 1, 0);
    step(0, 1, 0, 0, 0);
    for (int i = 0; i < 3; i++) step(0, 1, 1, 0, 32'h100 + i);
    for (int i = 3; i < 20; i++) begin
      step(0, 1, 1, 0, 32'h100 + i);
      step(0, 1, 0, 1, 0);
    end
    for (int i = 0; i < 3; i++) step(0, 1, 0, 1, 0);
    for (int i = 0; i < 8; i++) step(0, 1, 1, 0, 32'h200 + i);
    step(0, 1, 1, 1, 32'h2AA);
    for (int i = 0; i < 8; i++) step(0, 1, 0, 1, 0);
    step(0, 1, 1, 1, 32'h300);
    step(0, 1, 0, 1, 0);
    step(0, 1, 1, 0, 32'h400);
    step(0, 1, 1, 0, 32'h401);
    step(0, 1, 0, 1, 0);
    for (int i = 0; i < 5; i++) step(0, 0, 1, 1, 32'h4FF);
    step(1, 0, 0, 0, 0);
    for (int i = 0; i < 5; i++) step(0, 1, 1, 0, 32'h500 + i);
    step(1, 1, 1, 1, 32'h5FF);
    step(0, 1, 1, 0, 32'hA5);
    step(0, 1, 0, 1, 0);
    step(0, 1, 0, 0, 0);
    @(negedge Clk);
    EN = 1'b0; WR = 1'b0; RD = 1'b0;
    n = 0;
    while (sq.size() > 0 && n < 20) begin
      @(negedge Clk);
      n++;
    end
    if (sq.size() > 0) begin
      bad++;
      $display("FAIL drain pending=%0d", sq.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
